// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Result {hi = remainder, lo = quotient} is valid for the DONE cycle(s).
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            alucontrolE,
    input  logic [DATA_W-1:0]     srcaE,
    input  logic [DATA_W-1:0]     srcbE,
    input  logic                  flushE,
    input  logic                  stall_otherE,
    output logic                  div_stall,
    output logic                  div_valid,
    output logic [2*DATA_W-1:0]   div_result
);

    // Opcode encodings mirror EXE_DIV_OP / EXE_DIVU_OP from defines.vh.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_div;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_signed;
    logic                  w_start;
    logic                  w_last;
    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W:0]       w_shifted;
    logic [DATA_W:0]       w_trial;
    logic [DATA_W-1:0]     w_rem_step;
    logic [DATA_W-1:0]     w_quo_step;

    always_comb begin
        w_signed  = (alucontrolE == EXE_DIV_OP);
        w_start   = (w_signed || (alucontrolE == EXE_DIVU_OP)) && !flushE;
        w_abs_a   = (w_signed && srcaE[DATA_W-1]) ? -srcaE : srcaE;
        w_abs_b   = (w_signed && srcbE[DATA_W-1]) ? -srcbE : srcbE;
        w_last    = (r_cnt == LAST_CNT);
        // The quotient register doubles as the dividend shifter.
        w_shifted = {r_rem, r_quo[DATA_W-1]};
        w_trial   = w_shifted - {1'b0, r_div};
        if (!w_trial[DATA_W]) begin
            w_rem_step = w_trial[DATA_W-1:0];
            w_quo_step = {r_quo[DATA_W-2:0], 1'b1};
        end else begin
            w_rem_step = w_shifted[DATA_W-1:0];
            w_quo_step = {r_quo[DATA_W-2:0], 1'b0};
        end
    end

    always_comb begin
        w_next_state = r_state;
        div_stall    = 1'b0;
        unique case (r_state)
            IDLE: begin
                div_stall = w_start;
                if (w_start) w_next_state = BUSY;
            end
            BUSY: begin
                div_stall = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                if (!stall_otherE) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (flushE) w_next_state = IDLE;
        // Stall is suppressed while reset is held so the hazard unit sees a clean zero.
        if (flushE || !resetn) div_stall = 1'b0;
    end

    assign div_valid  = (r_state == DONE);
    assign div_result = r_result;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (flushE) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_sign_q <= w_signed && (srcaE[DATA_W-1] ^ srcbE[DATA_W-1]);
                        r_sign_r <= w_signed && srcaE[DATA_W-1];
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= {(r_sign_r ? -w_rem_step : w_rem_step),
                                     (r_sign_q ? -w_quo_step : w_quo_step)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corners, random DIV/DIVU against
// an arithmetic reference, plus flush, hold and asynchronous-reset scenarios.
module tb_div_unit;

    localparam logic [7:0] DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] ADD_OP  = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stall_otherE;
    logic        div_stall;
    logic        div_valid;
    logic [63:0] div_result;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alucontrolE  (alucontrolE),
        .srcaE        (srcaE),
        .srcbE        (srcbE),
        .flushE       (flushE),
        .stall_otherE (stall_otherE),
        .div_stall    (div_stall),
        .div_valid    (div_valid),
        .div_result   (div_result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: magnitude division, zero divisor gives all-ones quotient and
    // the dividend magnitude as remainder, then the sign rules are applied.
    function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic        sgn;
        logic        na;
        logic        nb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        sgn = (op == DIV_OP);
        na  = sgn && a[31];
        nb  = sgn && b[31];
        ma  = na ? 32'(0 - a) : a;
        mb  = nb ? 32'(0 - b) : b;
        q   = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
        r   = (mb == 0) ? ma : ma % mb;
        if (na ^ nb) q = 32'(0 - q);
        if (na)      r = 32'(0 - r);
        return {r, q};
    endfunction

    // Called just after a rising edge in an IDLE cycle; returns at the
    // falling edge of the first DONE cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string tag);
        int unsigned stalls;
        bit          seen;
        stalls = 0;
        seen   = 1'b0;
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (div_valid) begin
                seen = 1'b1;
                break;
            end
            if (div_stall) stalls++;
            @(posedge clk);
            #1;
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
        check({tag, "_stall_cycles"}, 64'(stalls), 64'd33);
        check({tag, "_done_stall"}, 64'(div_stall), 64'd0);
        check({tag, "_result"}, div_result, exp);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [7:0]  rop;
        bit          any_valid;

        resetn       = 1'b0;
        alucontrolE  = ADD_OP;
        srcaE        = '0;
        srcbE        = '0;
        flushE       = 1'b0;
        stall_otherE = 1'b0;
        #2;
        check("reset_stall", 64'(div_stall), 64'd0);
        check("reset_valid", 64'(div_valid), 64'd0);
        check("reset_result", div_result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_add_stall", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;

        run_div(DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");

        // Hold DONE for three edges with stall_otherE, then release.
        stall_otherE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                stall_otherE = 1'b0;
                alucontrolE  = ADD_OP;
            end
            @(negedge clk);
            check("hold_valid", 64'(div_valid), 64'd1);
            check("hold_result", div_result, {32'd2, 32'd14});
            check("hold_stall", 64'(div_stall), 64'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_valid", 64'(div_valid), 64'd0);
        check("release_stall", 64'(div_stall), 64'd0);

        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            srcaE = $urandom;
            srcbE = $urandom;
            @(negedge clk);
            check("nondiv_stall", 64'(div_stall), 64'd0);
            check("nondiv_result", div_result, {32'd2, 32'd14});
        end
        @(posedge clk);
        #1;

        // Directed corners, issued back to back.
        run_div(DIV_OP,  32'hFFFF_FF9C, 32'd7,         {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "div_m100_7");
        @(posedge clk); #1;
        run_div(DIV_OP,  32'd100,       32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, "div_100_m7");
        @(posedge clk); #1;
        run_div(DIV_OP,  32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, "div_m100_m7");
        @(posedge clk); #1;
        run_div(DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_intmin_m1");
        @(posedge clk); #1;
        run_div(DIVU_OP, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}, "divu_max_1");
        @(posedge clk); #1;
        run_div(DIVU_OP, 32'd5,         32'd0,         {32'h0000_0005, 32'hFFFF_FFFF}, "divu_5_0");
        @(posedge clk); #1;
        run_div(DIV_OP,  32'd7,         32'd0,         {32'h0000_0007, 32'hFFFF_FFFF}, "div_7_0");
        @(posedge clk); #1;
        run_div(DIV_OP,  32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'h0000_0001}, "div_m7_0");
        @(posedge clk); #1;

        for (int k = 0; k < 24; k++) begin
            rop = ($urandom_range(0, 1) == 0) ? DIV_OP : DIVU_OP;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = 32'(0 - $urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(rop, ra, rb, ref_div(rop, ra, rb), "rand");
            @(posedge clk);
            #1;
        end
        prev = ref_div(rop, ra, rb);

        // Flush in BUSY cycle 10.
        alucontrolE = DIVU_OP;
        srcaE       = 32'd1000;
        srcbE       = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        flushE = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;
        flushE      = 1'b0;
        alucontrolE = ADD_OP;
        @(negedge clk);
        check("flush_idle_stall", 64'(div_stall), 64'd0);
        check("flush_valid", 64'(div_valid), 64'd0);
        check("flush_result_kept", div_result, prev);
        any_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_valid) any_valid = 1'b1;
        end
        check("flush_no_valid", 64'(any_valid), 64'd0);
        @(posedge clk);
        #1;
        run_div(DIVU_OP, 32'd9, 32'd2, {32'd1, 32'd4}, "divu_9_2_after_flush");
        @(posedge clk);
        #1;

        // Asynchronous reset in BUSY cycle 5.
        alucontrolE = DIV_OP;
        srcaE       = 32'hFFFF_CFC7;
        srcbE       = 32'd17;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        check("arst_stall", 64'(div_stall), 64'd0);
        check("arst_valid", 64'(div_valid), 64'd0);
        check("arst_result", div_result, 64'd0);
        alucontrolE = ADD_OP;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("arst_add_stall", 64'(div_stall), 64'd0);
        check("arst_add_valid", 64'(div_valid), 64'd0);
        @(posedge clk);
        #1;
        run_div(DIV_OP, 32'hFFFF_CFC7, 32'd17, ref_div(DIV_OP, 32'hFFFF_CFC7, 32'd17), "div_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the execute stage, directly downstream of the ALU-control decoder. Consumes the decoded 8-bit `alucontrol` code; on `EXE_DIV_OP` or `EXE_DIVU_OP` it runs a radix-2 restoring division over 32 iterations. It stalls the pipeline through the hazard unit while busy, then presents {remainder, quotient} for the HI/LO write.

## Interface

Parameters:
- `DATA_W`, default 32: operand width. Iteration count equals `DATA_W`.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `alucontrolE`, input, 8: decoded op in E. Only the `defines.vh` macros `EXE_DIV_OP` and `EXE_DIVU_OP` launch the unit.
- `srcaE`, input, DATA_W: dividend (rs).
- `srcbE`, input, DATA_W: divisor (rt).
- `flushE`, input, 1: annuls E (exception or ERET). Aborts any division.
- `stall_otherE`, input, 1: E is held by another hazard source. The DONE state is held while this is high.
- `div_stall`, output, 1: to the hazard unit. Freezes F/D/E while the division is in progress.
- `div_valid`, output, 1: result valid, high only in DONE.
- `div_result`, output, 2*DATA_W: {hi = remainder, lo = quotient}.

## Operation

- FSM has three states: IDLE, BUSY, DONE. Reset puts it in IDLE with `div_result` = 0, `div_valid` = 0, `div_stall` = 0, and all internal registers 0.
- `start` = (`alucontrolE` == `EXE_DIV_OP` or `EXE_DIVU_OP`) && !`flushE`.
- IDLE → BUSY on `start`. The launch edge performs these latches:
  - signed flag = (op == `EXE_DIV_OP`);
  - sign_q = signed & (a[31] ^ b[31]);
  - sign_r = signed & a[31];
  - the magnitudes |a| and |b| (two's-complement negate when signed and the MSB is set; raw values otherwise);
  - partial remainder = 0;
  - iteration counter = 0.
- BUSY performs one restoring step per cycle:
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - trial = rem − |b| at DATA_W+1 bits;
  - if trial is non-negative, rem = trial and quotient LSB = 1; otherwise the quotient LSB = 0.
  - The counter increments. After step DATA_W (counter == DATA_W−1 at the edge), the state goes to DONE.
- Entering DONE registers the sign fix:
  - quo = sign_q ? −quo : quo;
  - rem = sign_r ? −rem : rem.
- DONE → IDLE when `stall_otherE` == 0. Otherwise it stays in DONE, holding `div_result` and `div_valid`. No relaunch happens while in DONE, even though `alucontrolE` is still DIV.
- Divide by zero: no trap, and the unit still takes the full latency.
  - Unsigned: quo = all ones, rem = a.
  - Signed: the result is whatever the magnitude path plus sign fix produces. For a = 7, b = 0 this is quo = 0xFFFFFFFF, rem = 7. For a = −7, b = 0 it is quo = 0x00000001, rem = −7.
- INT_MIN / −1 (signed): quo = 0x80000000, rem = 0.
- `flushE` == 1 in any state: next state is IDLE, counter cleared, `div_valid` low next cycle, and `div_result` keeps its last value.
- Asynchronous reset mid-operation returns everything to the reset values immediately. No partial result is exposed.

## Timing

- Launch cycle T: IDLE with `start`. `div_stall` = 1 combinationally in T.
- BUSY spans T+1 .. T+DATA_W, with `div_stall` = 1 throughout.
- DONE at T+DATA_W+1: `div_stall` = 0, `div_valid` = 1, `div_result` valid. The HI/LO write is taken on that edge.
- Total stall is DATA_W+1 cycles (33 for the default).
- `div_stall` = `start` in IDLE, 1 in BUSY, 0 in DONE, and forced to 0 whenever `flushE` = 1.
- Back-to-back DIVs: the second launches on the first IDLE cycle after DONE, with no bubble beyond that cycle.
- Non-divide ops never assert `div_stall` or change `div_result`.

## Test plan

- **DIVU 100/7:** response is stall high for 33 cycles, then `div_valid` = 1 with `div_result` = {0x00000002, 0x0000000E}.
- **DIV signed quadrants:**
  - −100/7 gives hi = 0xFFFFFFFE (−2), lo = 0xFFFFFFF2 (−14).
  - 100/−7 gives hi = 2, lo = −14.
  - −100/−7 gives hi = −2, lo = 14.
- **Corner values:**
  - DIV 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
  - DIVU 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
  - DIVU 5/0 gives {5, 0xFFFFFFFF}.
- **Flush:** pulse `flushE` in BUSY cycle 10. Response is `div_stall` = 0 that cycle, IDLE next, and no `div_valid`. A new DIVU 9/2 then gives {1, 4} after 33 cycles.
- **Hold:** with `stall_otherE` = 1 for 3 cycles in DONE, `div_valid` and `div_result` stay constant for those cycles, with no relaunch. IDLE follows the cycle after the release.
- **Async reset:** assert `resetn` = 0 in BUSY cycle 5. All outputs go to 0 immediately, with no clock edge needed. After release, an ADD op gives `div_stall` = 0.
